back_end: RTL

- Output-side controller of the memory-mapped coprocessor wrapper; the counterpart of the input-side front-end controller.
- After a start command, drains exactly `size` tokens from the accelerator's output FIFO and writes them to consecutive local-memory addresses from `base_addr`.
- Signals `done` to the host-side control logic.
- The FIFO has a 1-cycle registered read latency. The memory write port is synchronous and always ready.

---
 rtl/back_end.sv | 91 +++++++++
 1 files changed

// File: rtl/back_end.sv
// Output-side controller: drains a fixed number of tokens from the accelerator
// output FIFO into consecutive local-memory addresses and reports completion.
module back_end #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  size,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  empty,
  output logic                  rden,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [CNT_WIDTH-1:0]  wcount,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rd_rem_q, rd_rem_d;
  logic                  wren_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [CNT_WIDTH-1:0]  wcount_q;
  logic                  busy_q;
  logic                  done_q;

  assign rden   = (state_q == DRAIN) && !empty && (rd_rem_q != '0);
  assign wren   = wren_q;
  assign waddr  = waddr_q;
  assign wcount = wcount_q;
  assign busy   = busy_q;
  assign done   = done_q;

  always_comb begin
    state_d  = state_q;
    rd_rem_d = rd_rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_rem_d = size;
          state_d  = (size != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (rden) begin
          rd_rem_d = rd_rem_q - CNT_WIDTH'(1);
          if (rd_rem_q == CNT_WIDTH'(1)) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The FIFO returns data one cycle after rden, so each write is the registered read strobe.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      rd_rem_q <= '0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wcount_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_rem_q <= rd_rem_d;
      wren_q   <= rden;
      busy_q   <= (state_d == DRAIN) || (state_d == FLUSH);
      done_q   <= (state_d == DONE);
      if ((state_q == IDLE) && start) begin
        waddr_q  <= base_addr;
        wcount_q <= '0;
      end else if (wren_q) begin
        waddr_q  <= waddr_q + ADDR_WIDTH'(1);
        wcount_q <= wcount_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule
